// File: rtl/ace_snoop_buffer.sv
// ACE snoop path buffer: AC/CR/CD FIFOs with an in-flight snoop limiter.
// Optional CD framing checker enabled by ACE_SNOOP_BUF_CD_CHECK_EN.

module ace_snoop_buffer_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = 1;

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;

    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty = (wptr == rptr);
    assign in_ready  = en & ~full;
    assign out_valid = ~empty;
    assign out_data  = mem[rptr[AW-1:0]];
    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Storage write and pointer advance; reset clears contents so outputs read 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= in_data;
                wptr <= wptr + ONE;
            end
            if (pop) begin
                rptr <= rptr + ONE;
            end
        end
    end
endmodule

module ace_snoop_buffer #(
    parameter int ACE_AXADDR_WIDTH = 32,
    parameter int ACE_XDATA_WIDTH  = 256,
    parameter int AC_DEPTH         = 4,
    parameter int CR_DEPTH         = 4,
    parameter int CD_DEPTH         = 8,
    parameter int MAX_OUTSTANDING  = 4,
    parameter int CD_BEATS         = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        up_acvalid,
    output logic                        up_acready,
    input  logic [ACE_AXADDR_WIDTH-1:0] up_acaddr,
    input  logic [3:0]                  up_acsnoop,
    input  logic [2:0]                  up_acprot,
    output logic                        dn_acvalid,
    input  logic                        dn_acready,
    output logic [ACE_AXADDR_WIDTH-1:0] dn_acaddr,
    output logic [3:0]                  dn_acsnoop,
    output logic [2:0]                  dn_acprot,
    input  logic                        dn_crvalid,
    output logic                        dn_crready,
    input  logic [4:0]                  dn_crresp,
    output logic                        up_crvalid,
    input  logic                        up_crready,
    output logic [4:0]                  up_crresp,
    input  logic                        dn_cdvalid,
    output logic                        dn_cdready,
    input  logic [ACE_XDATA_WIDTH-1:0]  dn_cddata,
    input  logic                        dn_cdlast,
    output logic                        up_cdvalid,
    input  logic                        up_cdready,
    output logic [ACE_XDATA_WIDTH-1:0]  up_cddata,
    output logic                        up_cdlast,
    output logic                        proto_err
);
    localparam int ACW = ACE_AXADDR_WIDTH + 7;
    localparam int CDW = ACE_XDATA_WIDTH + 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] OMAX  = OW'(MAX_OUTSTANDING);
    localparam logic [OW-1:0] O_ONE = 1;

    logic          rdy_en;
    logic [OW-1:0] outst;
    logic          outst_ok;
    logic          ac_in_ready;
    logic          ac_hs;
    logic          cr_hs;
    logic          outst_udf;
    logic [ACW-1:0] ac_out;

    // Readies stay low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdy_en <= 1'b0;
        else     rdy_en <= 1'b1;
    end

    assign outst_ok   = (outst != OMAX);
    assign up_acready = ac_in_ready & outst_ok;
    assign ac_hs      = up_acvalid & up_acready;
    assign cr_hs      = up_crvalid & up_crready;
    assign outst_udf  = cr_hs & ~ac_hs & (outst == '0);

    // In-flight snoop count, saturating at zero on a stray response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outst <= '0;
        end else if (ac_hs && !cr_hs) begin
            outst <= outst + O_ONE;
        end else if (!ac_hs && cr_hs && outst != '0) begin
            outst <= outst - O_ONE;
        end
    end

    ace_snoop_buffer_fifo #(.W(ACW), .DEPTH(AC_DEPTH)) u_ac (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy_en),
        .in_valid  (up_acvalid & outst_ok),
        .in_ready  (ac_in_ready),
        .in_data   ({up_acaddr, up_acsnoop, up_acprot}),
        .out_valid (dn_acvalid),
        .out_ready (dn_acready),
        .out_data  (ac_out)
    );

    assign dn_acaddr  = ac_out[ACW-1:7];
    assign dn_acsnoop = ac_out[6:3];
    assign dn_acprot  = ac_out[2:0];

    ace_snoop_buffer_fifo #(.W(5), .DEPTH(CR_DEPTH)) u_cr (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy_en),
        .in_valid  (dn_crvalid),
        .in_ready  (dn_crready),
        .in_data   (dn_crresp),
        .out_valid (up_crvalid),
        .out_ready (up_crready),
        .out_data  (up_crresp)
    );

    ace_snoop_buffer_fifo #(.W(CDW), .DEPTH(CD_DEPTH)) u_cd (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy_en),
        .in_valid  (dn_cdvalid),
        .in_ready  (dn_cdready),
        .in_data   ({dn_cddata, dn_cdlast}),
        .out_valid (up_cdvalid),
        .out_ready (up_cdready),
        .out_data  ({up_cddata, up_cdlast})
    );

`ifdef ACE_SNOOP_BUF_CD_CHECK_EN
    localparam int EW = OW + 1;
    localparam int BW = (CD_BEATS > 1) ? $clog2(CD_BEATS) : 1;
    localparam logic [BW-1:0] BLAST = BW'(CD_BEATS - 1);
    localparam logic [BW-1:0] B_ONE = 1;
    localparam logic [EW-1:0] E_ONE = 1;

    logic [EW-1:0] expect_cnt;
    logic [BW-1:0] beat;
    logic          cd_hs;
    logic          dt_hs;
    logic          frame_err;
    logic          err_now;

    assign cd_hs = dn_cdvalid & dn_cdready;
    assign dt_hs = dn_crvalid & dn_crready & dn_crresp[0];
    assign frame_err = cd_hs & (dn_cdlast ? (beat != BLAST) : (beat == BLAST));
    assign err_now = frame_err | outst_udf
                   | (cd_hs & dn_cdlast & (expect_cnt == '0) & ~dt_hs);

    // Track expected bursts and beat position; latch any framing error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expect_cnt <= '0;
            beat       <= '0;
            proto_err  <= 1'b0;
        end else begin
            if (dt_hs && !(cd_hs && dn_cdlast)) begin
                expect_cnt <= expect_cnt + E_ONE;
            end else if (!dt_hs && cd_hs && dn_cdlast && expect_cnt != '0) begin
                expect_cnt <= expect_cnt - E_ONE;
            end
            if (cd_hs) begin
                if (dn_cdlast || beat == BLAST) beat <= '0;
                else                            beat <= beat + B_ONE;
            end
            if (err_now) proto_err <= 1'b1;
        end
    end
`else
    logic unused_udf;
    assign unused_udf = outst_udf;
    assign proto_err  = 1'b0;
`endif
endmodule
